// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int NREQ_DEF = 2;
    localparam int AW_DEF   = 32;
    localparam int DW_DEF   = 32;

    // Low address bits that must be zero for a word access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCESS  = 3'd1,
        CAPTURE = 3'd2,
        ERR     = 3'd3,
        RESP    = 3'd4
    } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr wins.
module rr_pick
    import dmem_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            any
);

    // Scan requesters in rotated order starting at ptr, stop at the first hit.
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one cs/oe/we data memory between NREQ requesters.
// One transaction in flight; every output is a flop.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting; pick a winner when any req is set
//   ACCESS  | gnt pulse, memory selected (write at negedge / read sampled)
//   CAPTURE | memory deselected, mem_dout captured at the ending edge
//   ERR     | gnt pulse for a misaligned request, memory untouched
//   RESP    | rsp_valid pulse with rsp_err / rsp_rdata
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rsp_valid,
    output logic               rsp_err,
    output logic [DW-1:0]      rsp_rdata,
    output logic               mem_cs,
    output logic               mem_oe,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_din,
    input  logic [DW-1:0]      mem_dout
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t state_q, state_d;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   w_q;
    logic            we_l_q;

    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            mem_cs_q, mem_cs_d;
    logic            mem_oe_q, mem_oe_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_din_q, mem_din_d;

    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_misaligned;
    logic            accept;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Steer the winning requester's command fields.
    always_comb begin
        sel_we         = req_we[pick_idx];
        sel_addr       = req_addr[int'(pick_idx)*AW +: AW];
        sel_wdata      = req_wdata[int'(pick_idx)*DW +: DW];
        sel_misaligned = (sel_addr[1:0] & ALIGN_MASK) != 2'b00;
        accept         = (state_q == IDLE) && pick_any;
        ptr_d          = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: fixed sequence per transaction.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = sel_misaligned ? ERR : ACCESS;
            ACCESS:  state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            ERR:     state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Winner bookkeeping and pointer advance on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            w_q    <= '0;
            we_l_q <= 1'b0;
        end else if (accept) begin
            ptr_q  <= ptr_d;
            w_q    <= pick_idx;
            we_l_q <= sel_we;
        end
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        gnt_d       = accept ? pick_gnt : '0;
        mem_cs_d    = (state_d == ACCESS);
        mem_we_d    = (state_d == ACCESS) && sel_we;
        mem_oe_d    = (state_d == ACCESS) && !sel_we;
        mem_addr_d  = (state_d == ACCESS) ? sel_addr  : mem_addr_q;
        mem_din_d   = (state_d == ACCESS) ? sel_wdata : mem_din_q;
        rsp_valid_d = (state_d == RESP) ? (NREQ'(1) << w_q) : '0;
        rsp_err_d   = (state_d == RESP) && (state_q == ERR);
        rsp_rdata_d = ((state_d == RESP) && (state_q == CAPTURE) && !we_l_q) ? mem_dout : '0;
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_cs_q    <= 1'b0;
            mem_oe_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_cs_q    <= mem_cs_d;
            mem_oe_q    <= mem_oe_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_cs    = mem_cs_q;
    assign mem_oe    = mem_oe_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  req_we = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  gnt;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_cs, mem_oe, mem_we;
    logic [31:0] mem_addr, mem_din;
    logic [31:0] mem_dout = '0;

    logic [31:0] mem [0:63];
    logic        preload = 1'b1;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    dmem_arbiter #(.NREQ(2), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .mem_cs    (mem_cs),
        .mem_oe    (mem_oe),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    // Memory: write on negedge, read data updated on posedge.
    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]  <= 32'hDEADBEEF;
            mem[12] <= 32'h11111111;
        end else if (mem_cs && mem_we) begin
            mem[mem_addr[7:2]] <= mem_din;
        end
    end

    always @(posedge clk) begin
        if (mem_cs && mem_oe) mem_dout <= mem[mem_addr[7:2]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        req[i]             = 1'b1;
        req_we[i]          = we;
        req_addr[i*32 +: 32]  = addr;
        req_wdata[i*32 +: 32] = wd;
    endtask

    function automatic logic [6:0] ctl();
        return {gnt, rsp_valid, mem_cs, mem_oe, mem_we};
    endfunction

    initial begin
        tick();
        tick();
        preload = 1'b0;
        check("reset_ctl", 64'(ctl()), 64'h0);
        check("reset_data", {rsp_err, rsp_rdata, mem_addr}, 64'h0);
        rst = 1'b0;

        // Idle stability
        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle_ctl", 64'({ctl(), rsp_err, rsp_rdata}), 64'h0);
        end

        // Single read of 0x10 by requester 0
        set_req(0, 1'b0, 32'h10, 32'h0);
        tick();
        check("rd_gnt", 64'(gnt), 64'h1);
        check("rd_access", 64'({mem_cs, mem_oe, mem_we}), 64'b110);
        check("rd_addr", 64'(mem_addr), 64'h10);
        req = '0;
        tick();
        check("rd_capture", 64'(ctl()), 64'h0);
        tick();
        check("rd_rsp_valid", 64'(rsp_valid), 64'h1);
        check("rd_rsp_data", {31'h0, rsp_err, rsp_rdata}, 64'hDEADBEEF);
        tick();
        check("rd_after", 64'({ctl(), rsp_err, rsp_rdata}), 64'h0);

        // Write 0xCAFEF00D to 0x20 by requester 1
        set_req(1, 1'b1, 32'h20, 32'hCAFEF00D);
        tick();
        check("wr_gnt", 64'(gnt), 64'h2);
        check("wr_access", 64'({mem_cs, mem_oe, mem_we}), 64'b101);
        check("wr_addr_din", {mem_addr, mem_din}, {32'h20, 32'hCAFEF00D});
        req = '0;
        tick();
        check("wr_we_one_cycle", 64'({mem_cs, mem_we}), 64'h0);
        tick();
        check("wr_rsp", {29'h0, rsp_valid, rsp_err, rsp_rdata}, {29'h0, 2'b10, 1'b0, 32'h0});
        tick();

        // Read back 0x20 by requester 0
        set_req(0, 1'b0, 32'h20, 32'h0);
        tick();
        check("rb_gnt", 64'(gnt), 64'h1);
        req = '0;
        tick();
        tick();
        check("rb_rsp", {29'h0, rsp_valid, rsp_err, rsp_rdata}, {29'h0, 2'b01, 1'b0, 32'hCAFEF00D});
        tick();

        // Contention from reset: both requesters held continuously
        rst = 1'b1;
        set_req(0, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b0, 32'h20, 32'h0);
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c % 4 == 1) check("cont_gnt", 64'(gnt), ((c / 4) % 2 == 0) ? 64'h1 : 64'h2);
            else            check("cont_nognt", 64'(gnt), 64'h0);
            if (c == 3)     check("cont_rsp0", {30'h0, rsp_valid, rsp_rdata}, {30'h0, 2'b01, 32'hDEADBEEF});
            if (c == 7)     check("cont_rsp1", {30'h0, rsp_valid, rsp_rdata}, {30'h0, 2'b10, 32'hCAFEF00D});
        end
        req = '0;
        tick();
        tick();
        check("cont_drain", 64'(ctl()), 64'h0);

        // Misaligned read 0x22 by requester 0
        set_req(0, 1'b0, 32'h22, 32'h0);
        tick();
        check("mis_gnt", 64'({gnt, mem_cs}), 64'b010);
        req = '0;
        tick();
        check("mis_rsp", {28'h0, rsp_valid, mem_cs, rsp_err, rsp_rdata}, {28'h0, 2'b01, 1'b0, 1'b1, 32'h0});
        tick();
        check("mis_after", 64'({rsp_valid, rsp_err}), 64'h0);

        // Misaligned write 0x13 by requester 1 (ptr now 1)
        set_req(1, 1'b1, 32'h13, 32'h55555555);
        tick();
        check("mis2_gnt", 64'({gnt, mem_cs, mem_we}), 64'b1000);
        req = '0;
        tick();
        check("mis2_rsp", 64'({rsp_valid, rsp_err, mem_cs}), 64'b1010);
        tick();
        check("mis2_mem", 64'(mem[4]), 64'hDEADBEEF);

        // Reset during ACCESS of a write to 0x30, before the negedge
        set_req(0, 1'b1, 32'h30, 32'hBAD0BAD0);
        tick();
        check("rst_access", 64'({gnt, mem_cs, mem_we}), 64'b0111);
        #1;
        rst = 1'b1;
        #1;
        check("rst_immediate", 64'({ctl(), rsp_err, rsp_rdata, mem_addr}), 64'h0);
        req = '0;
        tick();
        check("rst_hold", 64'(ctl()), 64'h0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("rst_no_rsp", 64'({rsp_valid, gnt}), 64'h0);
        end
        check("rst_mem_kept", 64'(mem[12]), 64'h11111111);

        // ptr back at 0: contention goes to requester 0
        set_req(0, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b0, 32'h20, 32'h0);
        tick();
        check("rst_ptr_gnt", 64'(gnt), 64'h1);
        req = '0;
        tick();
        tick();
        check("rst_ptr_rsp", {30'h0, rsp_valid, rsp_rdata}, {30'h0, 2'b01, 32'hDEADBEEF});
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one data_mem_v2-style data memory (cs/oe/we, 32-bit addr/din/dout) between NREQ requesters, e.g. the CPU load/store path and a debug loader.
- Round-robin arbitration; one transaction in flight at a time.
- Fixed per-transaction sequencing matches the memory's timing: write on negedge, dout updated on posedge.
- Misaligned accesses are rejected with an error response and never reach memory.

Parameters:
- NREQ, 2, number of requesters (≥2).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  single clock, rising-edge logic.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  request per requester; held until its gnt.
- req_we  in  NREQ  1 = write, 0 = read, per requester.
- req_addr  in  NREQ*AW  flat byte addresses; requester i uses slice [i*AW +: AW].
- req_wdata  in  NREQ*DW  flat write data.
- gnt  out  NREQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NREQ  one-hot, one-cycle completion pulse.
- rsp_err  out  1  valid with rsp_valid; 1 = misaligned.
- rsp_rdata  out  DW  read data, valid with rsp_valid.
- mem_cs  out  1  memory chip select.
- mem_oe  out  1  memory output enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_din  out  DW  memory write data.
- mem_dout  in  DW  memory read data.

Behaviour:
- All outputs are registered; rst clears every output and register to 0 and the FSM to IDLE.
- States:
  - IDLE: if any req is set at a posedge, pick the winner w from ptr and latch w's we/addr/wdata. If addr[1:0] != 0, go to ERR; otherwise go to ACCESS.
  - ACCESS, 1 cycle: gnt[w]=1, mem_cs=1, mem_we=we_l, mem_oe=~we_l, mem_addr=addr_l, mem_din=wdata_l. A write occurs at this cycle's negedge; a read is sampled by memory at the ending posedge. Then go to CAPTURE.
  - CAPTURE, 1 cycle: mem_cs/oe/we=0, mem_addr/mem_din hold. At the ending posedge, rdata_q <= mem_dout for reads, 0 for writes. Then go to RESP.
  - ERR, 1 cycle: gnt[w]=1, no mem_cs. Then go to RESP with err_l=1 and rdata_q=0.
  - RESP, 1 cycle: rsp_valid[w]=1, rsp_err=err_l, rsp_rdata=rdata_q. Then go to IDLE.
- Latency:
  - req sampled at edge E; gnt in cycle E+1; rsp_valid in cycle E+3 (ERR path: E+2).
  - Peak rate is one transaction per 4 cycles.
- Arbitration:
  - Round-robin starting at ptr; after granting w, ptr <= (w+1) mod NREQ.
  - ptr resets to 0, so the first contention goes to requester 0.
  - A single requester is granted regardless of ptr.
- Handshake:
  - The requester keeps req/we/addr/wdata stable until it sees gnt.
  - It must deassert req the cycle after gnt unless issuing a new request.
  - req still high in IDLE after rsp_valid is treated as a new request.
  - Inputs change freely outside IDLE and are ignored there.
- rsp_rdata and rsp_err are 0 whenever rsp_valid is all zero.
- Reset mid-operation:
  - Asynchronous clear; mem_cs drops immediately.
  - rst asserted during ACCESS before its negedge means no write occurs.
  - No response is issued for an aborted transaction.
- No gnt or rsp_valid is ever issued with rst high.

Decomposition:
- Package dmem_arb_pkg holds: state enum (IDLE, ACCESS, CAPTURE, ERR, RESP); ALIGN_MASK = 2'b11; default NREQ/AW/DW.
- Sub-module rr_pick: combinational round-robin picker. Inputs: req[NREQ], ptr. Outputs: one-hot grant, index, any.

Test Plan:
- Single read: memory preloaded 0x00000010 -> 0xDEADBEEF; req[0], addr 0x10, we=0 -> gnt[0] at E+1, mem_cs&oe in that cycle, rsp_valid[0] at E+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write then read-back: req[1] writes 0xCAFEF00D to 0x20 -> mem_we=1 for exactly one cycle; a following read of 0x20 returns 0xCAFEF00D.
- Contention: req[0] and req[1] both held continuously from reset -> grant order 0,1,0,1; each gnt is 4 cycles apart.
- Misaligned: read at 0x22 -> gnt at E+1, rsp_valid at E+2, rsp_err=1, rsp_rdata=0, mem_cs never asserted.
- Reset during ACCESS of a write to 0x30 before negedge -> all outputs 0 immediately, no rsp_valid, memory 0x30 unchanged, ptr=0 afterwards.
- Idle stability: req=0 for 20 cycles -> all outputs stay 0 and the FSM stays in IDLE.
